// File: rtl/audio_pkg.sv
// Shared definitions for the stereo averaging stage: default sample width,
// default tap count and the handshake FSM state encoding.
package audio_pkg;

  localparam int unsigned DATA_W_DEF = 24;
  localparam int unsigned LOG2_N_DEF = 3;

  typedef enum logic [2:0] {
    WAIT_IN,
    CAPTURE,
    UPDATE,
    WAIT_OUT,
    PUSH
  } state_t;

endpackage

// File: rtl/avg_history_ch.sv
// One channel of the N-tap moving average: circular history, running sum
// and the registered shifted average.
// Ports:
//   CLOCK_50  clock (rising edge)
//   reset     synchronous active-high; clears history, sum and output
//   i_update  replace hist[i_wptr] with i_sample and refresh the average
//   i_wptr    history slot holding the oldest sample
//   i_sample  new signed sample
//   o_avg     floor(sum / N), held between updates
module avg_history_ch #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned LOG2_N = 3
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     i_update,
  input  logic [LOG2_N-1:0]        i_wptr,
  input  logic signed [DATA_W-1:0] i_sample,
  output logic signed [DATA_W-1:0] o_avg
);

  localparam int unsigned N     = 1 << LOG2_N;
  localparam int unsigned SUM_W = DATA_W + LOG2_N;

  logic signed [DATA_W-1:0] r_hist [N];
  logic signed [SUM_W-1:0]  r_sum;
  logic signed [SUM_W-1:0]  w_sample_ext;
  logic signed [SUM_W-1:0]  w_oldest_ext;
  logic signed [SUM_W-1:0]  w_sum_next;

  // Sign-extend into the sum width; the sum of N samples cannot overflow it.
  assign w_sample_ext = $signed({{LOG2_N{i_sample[DATA_W-1]}}, i_sample});
  assign w_oldest_ext = $signed({{LOG2_N{r_hist[i_wptr][DATA_W-1]}}, r_hist[i_wptr]});
  assign w_sum_next   = r_sum + w_sample_ext - w_oldest_ext;

  // The average is taken from the next sum so it is valid one cycle after UPDATE.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_hist[LOG2_N'(i)] <= '0;
      end
      r_sum <= '0;
      o_avg <= '0;
    end else if (i_update) begin
      r_hist[i_wptr] <= i_sample;
      r_sum          <= w_sum_next;
      o_avg          <= w_sum_next[SUM_W-1:LOG2_N];
    end
  end

endmodule

// File: rtl/stereo_avg_stage.sv
// Stereo moving-average stage between the codec ADC FIFO and DAC FIFO.
// Strict read-one/write-one handshake: a new sample pair is popped only
// after the previous average has been pushed.
// Ports:
//   CLOCK_50, reset                      clock, synchronous active-high reset
//   read_ready, readdata_left/right      codec ADC side (sample pair available)
//   write_ready                          codec DAC side can accept a pair
//   read, write                          registered one-cycle pop/push strobes
//   writedata_left/right                 registered N-tap averages
module stereo_avg_stage
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LOG2_N = LOG2_N_DEF
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     read_ready,
  input  logic signed [DATA_W-1:0] readdata_left,
  input  logic signed [DATA_W-1:0] readdata_right,
  input  logic                     write_ready,
  output logic                     read,
  output logic                     write,
  output logic signed [DATA_W-1:0] writedata_left,
  output logic signed [DATA_W-1:0] writedata_right
);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [LOG2_N-1:0]        r_wptr;
  logic signed [DATA_W-1:0] r_in_l;
  logic signed [DATA_W-1:0] r_in_r;
  logic                     w_update;

  assign w_update = (r_state == UPDATE);

  // Next-state logic; ready inputs only matter in their waiting states.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WAIT_IN:  if (read_ready)  w_state_next = CAPTURE;
      CAPTURE:                   w_state_next = UPDATE;
      UPDATE:                    w_state_next = WAIT_OUT;
      WAIT_OUT: if (write_ready) w_state_next = PUSH;
      PUSH:                      w_state_next = WAIT_IN;
      default:                   w_state_next = WAIT_IN;
    endcase
  end

  // State register, strobes decoded from the next state, input capture, wptr.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= WAIT_IN;
      read    <= 1'b0;
      write   <= 1'b0;
      r_wptr  <= '0;
      r_in_l  <= '0;
      r_in_r  <= '0;
    end else begin
      r_state <= w_state_next;
      read    <= (w_state_next == CAPTURE);
      write   <= (w_state_next == PUSH);
      if (r_state == CAPTURE) begin
        r_in_l <= readdata_left;
        r_in_r <= readdata_right;
      end
      if (w_update) begin
        r_wptr <= r_wptr + LOG2_N'(1);
      end
    end
  end

  avg_history_ch #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_left (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .i_update (w_update),
    .i_wptr   (r_wptr),
    .i_sample (r_in_l),
    .o_avg    (writedata_left)
  );

  avg_history_ch #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_right (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .i_update (w_update),
    .i_wptr   (r_wptr),
    .i_sample (r_in_r),
    .o_avg    (writedata_right)
  );

endmodule

// File: tb/tb_stereo_avg_stage.sv
// Self-checking bench for stereo_avg_stage: transaction-level timing model
// plus sliding-window average model, directed cases and random traffic.
module tb_stereo_avg_stage;

  localparam int DW = 24;
  localparam int LN = 3;
  localparam int N  = 8;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset;
  logic                 read_ready;
  logic                 write_ready;
  logic signed [DW-1:0] readdata_left;
  logic signed [DW-1:0] readdata_right;
  logic                 read;
  logic                 write;
  logic signed [DW-1:0] writedata_left;
  logic signed [DW-1:0] writedata_right;

  always #5 CLOCK_50 = ~CLOCK_50;

  stereo_avg_stage #(.DATA_W(DW), .LOG2_N(LN)) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .read_ready      (read_ready),
    .readdata_left   (readdata_left),
    .readdata_right  (readdata_right),
    .write_ready     (write_ready),
    .read            (read),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  // floor(sum of window / N) with plain integer arithmetic
  function automatic int floor_avg(input int h[$]);
    longint s = 0;
    foreach (h[i]) s += h[i];
    if (s >= 0) return int'(s / N);
    return int'(-((-s + N - 1) / N));
  endfunction

  // Model state: timeline of the current transaction in absolute cycle numbers.
  int  cyc = 0;
  bit  m_on = 1'b0;
  bit  m_active = 1'b0;
  int  m_idle_from = 0;
  int  m_read_due = -1;
  int  m_out_due = -1;
  int  m_write_due = -1;
  int  m_hl[$];
  int  m_hr[$];
  int  m_pend_l = 0, m_pend_r = 0;
  int  m_last_l = 0, m_last_r = 0;
  int  n_read = 0, n_write = 0;
  int  q_l[$];
  int  q_r[$];

  always @(negedge CLOCK_50) begin
    if (m_on) begin
      check("read_strobe", read, (cyc == m_read_due));
      check("write_strobe", write, (cyc == m_write_due));
      check("writedata_left", writedata_left, m_last_l);
      check("writedata_right", writedata_right, m_last_r);
      if (read) n_read++;
      if (write) begin
        n_write++;
        q_l.push_back(int'(writedata_left));
        q_r.push_back(int'(writedata_right));
      end
      if (m_active && cyc == m_write_due) begin
        m_active    = 1'b0;
        m_write_due = -1;
        m_out_due   = -1;
        m_idle_from = cyc + 1;
      end
      if (m_active && cyc == m_read_due) begin
        m_hl.push_back(int'(readdata_left));
        m_hr.push_back(int'(readdata_right));
        if (m_hl.size() > N) void'(m_hl.pop_front());
        if (m_hr.size() > N) void'(m_hr.pop_front());
        m_pend_l = floor_avg(m_hl);
        m_pend_r = floor_avg(m_hr);
      end
      if (m_active && cyc + 1 == m_out_due) begin
        m_last_l = m_pend_l;
        m_last_r = m_pend_r;
      end
      if (m_active && m_out_due >= 0 && cyc >= m_out_due && m_write_due < 0 && write_ready)
        m_write_due = cyc + 1;
      if (!m_active && cyc >= m_idle_from && read_ready && !reset) begin
        m_active   = 1'b1;
        m_read_due = cyc + 1;
        m_out_due  = cyc + 3;
      end
    end
    if (reset) begin
      m_on        = 1'b1;
      m_active    = 1'b0;
      m_read_due  = -1;
      m_out_due   = -1;
      m_write_due = -1;
      m_idle_from = cyc + 1;
      m_hl.delete();
      m_hr.delete();
      m_last_l = 0;
      m_last_r = 0;
    end
    cyc++;
  end

  task automatic do_reset();
    reset      = 1'b1;
    read_ready = 1'b0;
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    q_l.delete();
    q_r.delete();
  endtask

  // Present a pair and hold it until the pop strobe has been seen.
  task automatic send(input int l, input int r);
    bit got = 1'b0;
    readdata_left  = DW'(l);
    readdata_right = DW'(r);
    read_ready     = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLOCK_50);
      if (read) got = 1'b1;
    end
    check("read_seen", got, 1);
    @(posedge CLOCK_50);
    #1;
    read_ready = 1'b0;
  endtask

  task automatic wait_q(input int n);
    for (int i = 0; i < 500 && q_l.size() < n; i++) @(posedge CLOCK_50);
    #1;
    check("write_count", q_l.size(), n);
  endtask

  int exp_v;
  int nr0, nw0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    read_ready     = 1'b0;
    write_ready    = 1'b0;
    readdata_left  = '0;
    readdata_right = '0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_wd_left", writedata_left, 0);
    check("rst_wd_right", writedata_right, 0);
    repeat (5) @(posedge CLOCK_50);
    #1;

    // Step: ramp up over the zero-filled history, then settle
    write_ready = 1'b1;
    for (int k = 0; k < 10; k++) send(800, -800);
    wait_q(10);
    for (int k = 0; k < 10 && k < q_l.size(); k++) begin
      exp_v = 100 * ((k + 1 < 8) ? k + 1 : 8);
      check("step_left", q_l[k], exp_v);
      check("step_right", q_r[k], -exp_v);
    end

    // Impulse on both channels
    do_reset();
    send(8388607, -1);
    for (int k = 0; k < 9; k++) send(0, 0);
    wait_q(10);
    for (int k = 0; k < 10 && k < q_l.size(); k++) begin
      check("impulse_left", q_l[k], (k < 8) ? 1048575 : 0);
      check("impulse_right", q_r[k], (k < 8) ? -1 : 0);
    end

    // Backpressure: pending output blocks further reads
    do_reset();
    write_ready = 1'b0;
    send(123, 456);
    readdata_left  = DW'(77);
    readdata_right = DW'(-77);
    read_ready     = 1'b1;
    nr0 = n_read;
    nw0 = n_write;
    repeat (20) @(posedge CLOCK_50);
    #1;
    check("bp_no_read", n_read, nr0);
    check("bp_no_write", n_write, nw0);
    check("bp_hold_left", writedata_left, 15);
    check("bp_hold_right", writedata_right, 57);
    write_ready = 1'b1;
    for (int i = 0; i < 50 && n_read == nr0; i++) @(posedge CLOCK_50);
    #1;
    check("bp_read_after", n_read, nr0 + 1);
    check("bp_one_write", n_write, nw0 + 1);
    read_ready = 1'b0;
    wait_q(2);
    if (q_l.size() == 2) begin
      check("bp_second_left", q_l[1], 25);
      check("bp_second_right", q_r[1], 47);
    end

    // Reset while the captured sample is being folded in
    do_reset();
    send(5000, 5000);
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge CLOCK_50);
    #1;
    check("midop_no_write", q_l.size(), 0);
    send(8000, -8000);
    wait_q(1);
    if (q_l.size() == 1) begin
      check("midop_left", q_l[0], 1000);
      check("midop_right", q_r[0], -1000);
    end

    // Wrap: ramp 1..20 exercises the circular pointer several times
    do_reset();
    for (int k = 1; k <= 20; k++) send(k, -k);
    wait_q(20);
    if (q_l.size() == 20) begin
      check("wrap_8th_left", q_l[7], 4);
      check("wrap_20th_left", q_l[19], 16);
      check("wrap_20th_right", q_r[19], -17);
    end

    // Random traffic with occasional resets
    do_reset();
    nr0 = n_read;
    for (int c = 0; c < 3000; c++) begin
      if (n_read != nr0 || !read_ready) begin
        nr0 = n_read;
        case ($urandom_range(0, 7))
          0:       readdata_left = DW'(24'h7FFFFF);
          1:       readdata_left = DW'(24'h800000);
          default: readdata_left = DW'($urandom);
        endcase
        readdata_right = DW'($urandom);
        read_ready     = ($urandom_range(0, 1) == 1);
      end
      write_ready = ($urandom_range(0, 3) != 0);
      reset       = ($urandom_range(0, 199) == 0);
      @(posedge CLOCK_50);
      #1;
    end
    reset       = 1'b0;
    read_ready  = 1'b0;
    write_ready = 1'b1;
    repeat (10) @(posedge CLOCK_50);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
